ghost_path_sched: RTL

Scheduler that shares one maze path-lookup engine among the four ghosts. On each game-logic tick it issues one lookup per enabled ghost in rotating round-robin order and waits for each result. It latches each returned direction into a per-ghost direction register, which drives the ghost_N_dir inputs of the draw controller and the ghost movement logic. It sits inside the game-logic domain, between the tick source and the path engine.

---
 rtl/game_pkg.sv | 30 +++
 rtl/rr_next_sel.sv | 29 ++
 rtl/ghost_path_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// ============================================================================
// Package : game_pkg
// Brief   : Shared game-logic types: direction codes, ghost count, scheduler states.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int NUM_GHOSTS = 4;

    // One-hot {U,D,L,R} = bits {3,2,1,0}; all-zero means stopped.
    typedef logic [3:0] dir_t;

    localparam dir_t DIR_UP    = 4'b1000;
    localparam dir_t DIR_DOWN  = 4'b0100;
    localparam dir_t DIR_LEFT  = 4'b0010;
    localparam dir_t DIR_RIGHT = 4'b0001;
    localparam dir_t DIR_NONE  = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_NEXT  = 2'd3
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_next_sel.sv
// ============================================================================
// Module : rr_next_sel
// Brief  : Combinational cyclic find-first-set over a request mask, starting at i_cur.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_next_sel #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_pending,
    input  logic [ID_W-1:0]    i_cur,
    output logic [ID_W-1:0]    o_sel
);

    // Walk from the farthest offset back to i_cur so the nearest set bit wins.
    always_comb begin
        o_sel = i_cur;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_pending[(int'(i_cur) + i) % NUM_REQ]) begin
                o_sel = ID_W'((int'(i_cur) + i) % NUM_REQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ghost_path_sched.sv
// ============================================================================
// Module : ghost_path_sched
// Brief  : Round-robin scheduler sharing one path-lookup engine among the ghosts.
//          Optional WAIT timeout is built when PATH_TIMEOUT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghost_path_sched #(
    parameter int NUM_GHOSTS = 4,
    parameter int DIR_W      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [NUM_GHOSTS-1:0]         ghost_en,
    output logic                          eng_start,
    output logic [$clog2(NUM_GHOSTS)-1:0] eng_id,
    input  logic                          eng_done,
    input  logic [DIR_W-1:0]              eng_dir,
    output logic [NUM_GHOSTS*DIR_W-1:0]   ghost_dir,
    output logic                          sched_done,
    output logic                          overrun,
    output logic                          dir_err
);
    import game_pkg::*;

    localparam int c_ID_W = $clog2(NUM_GHOSTS);

    sched_state_t                r_state;
    sched_state_t                w_state_nxt;
    logic [NUM_GHOSTS-1:0]       r_pending;
    logic [c_ID_W-1:0]           r_cur;
    logic [c_ID_W-1:0]           r_start_ptr;
    logic [c_ID_W-1:0]           w_sel;
    logic [NUM_GHOSTS*DIR_W-1:0] r_ghost_dir;
    logic                        r_sched_done;
    logic                        w_result;
    logic                        w_dir_ok;
    logic                        w_timeout;

    function automatic logic [c_ID_W-1:0] f_wrap_inc(input logic [c_ID_W-1:0] v);
        return (v == c_ID_W'(NUM_GHOSTS - 1)) ? '0 : v + 1'b1;
    endfunction

    rr_next_sel #(
        .NUM_REQ (NUM_GHOSTS)
    ) u_rr_next_sel (
        .i_pending (r_pending),
        .i_cur     (r_cur),
        .o_sel     (w_sel)
    );

`ifdef PATH_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Counts completed WAIT cycles; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_WAIT)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && !eng_done
                       && (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_result   = (r_state == ST_WAIT) && eng_done;
    assign w_dir_ok   = $onehot(eng_dir);
    assign eng_start  = (r_state == ST_ISSUE);
    assign eng_id     = eng_start ? w_sel : r_cur;
    assign dir_err    = (w_result && !w_dir_ok) || w_timeout;
    assign overrun    = tick && (r_state != ST_IDLE);
    assign ghost_dir  = r_ghost_dir;
    assign sched_done = r_sched_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (tick && (ghost_en != '0)) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_result || w_timeout) w_state_nxt = ST_NEXT;
            ST_NEXT:  w_state_nxt = (r_pending != '0) ? ST_ISSUE : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_cur        <= '0;
            r_start_ptr  <= '0;
            r_ghost_dir  <= '0;
            r_sched_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sched_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tick) begin
                        r_pending <= ghost_en;
                        r_cur     <= r_start_ptr;
                        if (ghost_en == '0) r_sched_done <= 1'b1;
                    end
                end
                ST_ISSUE: r_cur <= w_sel;
                ST_WAIT: begin
                    if (w_result || w_timeout) begin
                        if (w_result && w_dir_ok) begin
                            r_ghost_dir[int'(r_cur)*DIR_W +: DIR_W] <= eng_dir;
                        end
                        r_pending[r_cur] <= 1'b0;
                    end
                end
                ST_NEXT: begin
                    if (r_pending != '0) begin
                        r_cur <= f_wrap_inc(r_cur);
                    end else begin
                        r_sched_done <= 1'b1;
                        // Rotation ignores enables so first service moves 0,1,2,3,...
                        r_start_ptr  <= f_wrap_inc(r_start_ptr);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
